// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, FSM state type and index decode for rr_arbiter4
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating priority search starting just after ptr
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Offsets 1..4 wrap so that ptr itself is checked last.
  always_comb begin
    logic             w_found;
    logic [IDX_W-1:0] w_cand;
    w_found = 1'b0;
    w_cand  = '0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ptr + IDX_W'(k);
      if (!w_found && req[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter with registered one-hot grant;
// define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout_pulse
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 15) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_param_check
    $error("rr_arbiter4: MAX_HOLD must be 1..15 and fit in CNT_W bits");
  end

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_valid;
  logic [IDX_W-1:0] r_ptr;

  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic             w_norm_rel;
  logic             w_force;
  logic             w_release;

  rr_pick4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_norm_rel = done | ~req[r_gnt_idx];
  assign w_release  = w_norm_rel | w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= 2'b11;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= GRANT;
            r_gnt_idx   <= w_idx;
            r_gnt       <= decode(w_idx);
            r_gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_force = (r_state == GRANT) && (r_cnt == CNT_W'(MAX_HOLD - 1));

  // The pulse marks only forced releases; a voluntary release on the same edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == GRANT) && w_force && !w_norm_rel;
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (!w_release) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign timeout_pulse = r_timeout;
`else
  assign w_force       = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed self-checking bench for rr_arbiter4
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_pulse;

  int n_checks = 0;
  int n_fails  = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .done          (done),
    .gnt           (gnt),
    .gnt_idx       (gnt_idx),
    .gnt_valid     (gnt_valid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Checks the full output set for one cycle; an idle expectation means gnt=0, valid=0.
  task automatic expect_grant(input string tag, input logic act, input logic [1:0] idx);
    logic [3:0] onehot;
    onehot      = 4'b0000;
    onehot[idx] = 1'b1;
    if (act) begin
      chk({tag, "_gnt"}, gnt, onehot);
      chk({tag, "_idx"}, {2'b00, gnt_idx}, {2'b00, idx});
      chk({tag, "_valid"}, {3'b000, gnt_valid}, 4'b0001);
    end else begin
      chk({tag, "_gnt"}, gnt, 4'b0000);
      chk({tag, "_valid"}, {3'b000, gnt_valid}, 4'b0000);
    end
  endtask

  initial begin
    logic [1:0] order [4];
    order = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    step;
    step;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_idx", {2'b00, gnt_idx}, 4'b0000);
    chk("rst_valid", {3'b000, gnt_valid}, 4'b0000);
    chk("rst_tp", {3'b000, timeout_pulse}, 4'b0000);

    rst_n = 1'b1;
    req   = 4'b0101;
    step;
    expect_grant("first", 1'b1, 2'd0);

    done = 1'b1;
    step;
    expect_grant("rel0", 1'b0, 2'd0);
    done = 1'b0;
    step;
    expect_grant("g2", 1'b1, 2'd2);
    done = 1'b1;
    step;
    expect_grant("rel2", 1'b0, 2'd0);
    done = 1'b0;
    step;
    expect_grant("g0b", 1'b1, 2'd0);

    req = 4'b1111;
    step;
    expect_grant("all_hold0", 1'b1, 2'd0);
    done = 1'b1;
    step;
    expect_grant("all_gap0", 1'b0, 2'd0);
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      expect_grant("all_grant", 1'b1, order[i]);
      step;
      expect_grant("all_hold", 1'b1, order[i]);
      done = 1'b1;
      step;
      expect_grant("all_gap", 1'b0, 2'd0);
      done = 1'b0;
    end

    req = 4'b0100;
    step;
    expect_grant("drop_g2", 1'b1, 2'd2);
    req = 4'b0000;
    step;
    expect_grant("drop_rel", 1'b0, 2'd0);
    step;
    expect_grant("drop_idle", 1'b0, 2'd0);
    chk("idx_kept", {2'b00, gnt_idx}, 4'b0010);

    req = 4'b0010;
    step;
    expect_grant("pre_rst", 1'b1, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_grant("async_rst", 1'b0, 2'd0);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    expect_grant("post_rst", 1'b1, 2'd1);

    done = 1'b1;
    step;
    done = 1'b0;
    req  = 4'b1000;
    step;
    expect_grant("g3", 1'b1, 2'd3);
    done = 1'b1;
    step;
    done = 1'b0;
    step;
    expect_grant("wrap_same", 1'b1, 2'd3);
    req = 4'b1111;
    step;
    expect_grant("nonowner_ignored", 1'b1, 2'd3);
    done = 1'b1;
    step;
    expect_grant("done_priority", 1'b0, 2'd0);
    done = 1'b0;
    step;
    expect_grant("wrap_to0", 1'b1, 2'd0);

    req  = 4'b1000;
    done = 1'b1;
    step;
    done = 1'b0;
    step;
    expect_grant("hold3", 1'b1, 2'd3);
    req = 4'b1001;
`ifdef ARB_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) begin
      step;
      expect_grant("to_hold", 1'b1, 2'd3);
      chk("to_nopulse", {3'b000, timeout_pulse}, 4'b0000);
    end
    step;
    expect_grant("to_rel", 1'b0, 2'd0);
    chk("to_pulse", {3'b000, timeout_pulse}, 4'b0001);
    step;
    expect_grant("to_next", 1'b1, 2'd0);
    chk("to_pulse_end", {3'b000, timeout_pulse}, 4'b0000);
`else
    for (int i = 0; i < 12; i++) begin
      step;
      expect_grant("hold_forever", 1'b1, 2'd3);
      chk("tp_zero", {3'b000, timeout_pulse}, 4'b0000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
